// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: EX->MEM register, variable-latency load completion,
// load-data alignment, WB/forwarding drive and load-outstanding stall request.
module mem_stage_lsu #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned RF_AW     = 5,
  parameter int unsigned STALL_W   = 6,
  parameter int unsigned STAGE_IDX = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STALL_W-1:0] stall,
  input  logic               ex_valid,
  input  logic [PC_W-1:0]    ex_pc,
  input  logic               ex_load,
  input  logic [1:0]         ex_ld_size,
  input  logic               ex_ld_unsigned,
  input  logic               ex_rf_we,
  input  logic [RF_AW-1:0]   ex_rf_waddr,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic               dmem_rvalid,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               wb_valid,
  output logic [PC_W-1:0]    wb_pc,
  output logic               wb_rf_we,
  output logic [RF_AW-1:0]   wb_rf_waddr,
  output logic [DATA_W-1:0]  wb_rf_wdata,
  output logic               fwd_we,
  output logic [RF_AW-1:0]   fwd_waddr,
  output logic [DATA_W-1:0]  fwd_wdata,
  output logic               fwd_pending,
  output logic               stallreq
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_e;

  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               load_q, load_d;
  logic [1:0]         ld_size_q, ld_size_d;
  logic               ld_uns_q, ld_uns_d;
  logic               rf_we_q, rf_we_d;
  logic [RF_AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [DATA_W-1:0]  hold_data_q, hold_data_d;

  logic               capture, bubble, ready;
  logic [OFF_W-1:0]   off_half;
  logic [7:0]         byte_lane;
  logic [15:0]        half_lane;
  logic [DATA_W-1:0]  aligned;
  logic [DATA_W-1:0]  wdata;
  logic               unused_stall;

  assign unused_stall = ^stall;
  assign capture      = ~stall[STAGE_IDX];
  assign bubble       = stall[STAGE_IDX] & ~stall[STAGE_IDX+1];

  // Align the live memory word by offset, size and signedness.
  always_comb begin
    off_half  = off_q & ~OFF_W'(1);
    byte_lane = 8'(dmem_rdata >> {off_q, 3'b000});
    half_lane = 16'(dmem_rdata >> {off_half, 3'b000});
    case (ld_size_q)
      2'd0:    aligned = ld_uns_q ? {{(DATA_W-8){1'b0}}, byte_lane}
                                  : {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      2'd1:    aligned = ld_uns_q ? {{(DATA_W-16){1'b0}}, half_lane}
                                  : {{(DATA_W-16){half_lane[15]}}, half_lane};
      default: aligned = dmem_rdata;
    endcase
  end

  // Next-state for the slot register and load FSM: bubble > capture > WAIT->HOLD.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    pc_d        = pc_q;
    load_d      = load_q;
    ld_size_d   = ld_size_q;
    ld_uns_d    = ld_uns_q;
    rf_we_d     = rf_we_q;
    rf_waddr_d  = rf_waddr_q;
    result_d    = result_q;
    off_d       = off_q;
    hold_data_d = hold_data_q;
    if (bubble) begin
      valid_d = 1'b0;
      rf_we_d = 1'b0;
      state_d = ST_IDLE;
    end else if (capture) begin
      // A response arriving now belongs to the leaving slot and is not kept.
      valid_d    = ex_valid;
      pc_d       = ex_pc;
      load_d     = ex_load;
      ld_size_d  = ex_ld_size;
      ld_uns_d   = ex_ld_unsigned;
      rf_we_d    = ex_rf_we;
      rf_waddr_d = ex_rf_waddr;
      result_d   = ex_result;
      off_d      = ex_result[OFF_W-1:0];
      state_d    = (ex_valid & ex_load) ? ST_WAIT : ST_IDLE;
    end else if (state_q == ST_WAIT && dmem_rvalid) begin
      state_d     = ST_HOLD;
      hold_data_d = aligned;
    end
  end

  // Slot register and FSM state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      pc_q        <= '0;
      load_q      <= 1'b0;
      ld_size_q   <= '0;
      ld_uns_q    <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      result_q    <= '0;
      off_q       <= '0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      load_q      <= load_d;
      ld_size_q   <= ld_size_d;
      ld_uns_q    <= ld_uns_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      result_q    <= result_d;
      off_q       <= off_d;
      hold_data_q <= hold_data_d;
    end
  end

  // WB, forwarding and stall outputs derived from slot state and response.
  always_comb begin
    ready       = (state_q != ST_WAIT) | dmem_rvalid;
    wdata       = load_q ? ((state_q == ST_HOLD) ? hold_data_q : aligned) : result_q;
    wb_valid    = valid_q & ready;
    wb_pc       = pc_q;
    wb_rf_we    = valid_q & rf_we_q & ready;
    wb_rf_waddr = rf_waddr_q;
    wb_rf_wdata = wdata;
    fwd_we      = valid_q & rf_we_q & ready;
    fwd_waddr   = rf_waddr_q;
    fwd_wdata   = wdata;
    fwd_pending = valid_q & rf_we_q & (state_q == ST_WAIT) & ~dmem_rvalid;
    stallreq    = valid_q & (state_q == ST_WAIT) & ~dmem_rvalid;
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: scoreboard of expected WB writes plus direct
// checks of stall/forwarding behaviour and reset.
module tb_mem_stage_lsu;

  localparam int S = 3;

  logic        clk, rst_n;
  logic [5:0]  base_stall, stall;
  logic        ex_valid, ex_load, ex_ld_unsigned, ex_rf_we;
  logic [31:0] ex_pc, ex_result;
  logic [1:0]  ex_ld_size;
  logic [4:0]  ex_rf_waddr;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_rf_we, fwd_we, fwd_pending, stallreq;
  logic [31:0] wb_pc, wb_rf_wdata, fwd_wdata;
  logic [4:0]  wb_rf_waddr, fwd_waddr;

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // The stage's own stall request freezes EX/MEM and WB, like the core's stall controller.
  assign stall = base_stall | (stallreq ? 6'b011111 : 6'b000000);

  mem_stage_lsu #(.DATA_W(32), .PC_W(32), .RF_AW(5), .STALL_W(6), .STAGE_IDX(S)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_load(ex_load), .ex_ld_size(ex_ld_size),
    .ex_ld_unsigned(ex_ld_unsigned), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_result(ex_result), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
    .wb_rf_wdata(wb_rf_wdata), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending), .stallreq(stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: a write happens when WB is valid and the WB register is not stopped.
  always @(negedge clk) begin
    if (rst_n && wb_valid && !stall[S+1]) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_wb_pc", {32'd0, wb_pc}, 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_pc",        {32'd0, wb_pc},       {32'd0, e.pc});
        check("sb_rf_we",     {63'd0, wb_rf_we},    {63'd0, e.we});
        check("sb_rf_waddr",  {59'd0, wb_rf_waddr}, {59'd0, e.waddr});
        check("sb_rf_wdata",  {32'd0, wb_rf_wdata}, {32'd0, e.wdata});
        check("sb_fwd_we",    {63'd0, fwd_we},      {63'd0, e.we});
        check("sb_fwd_wdata", {32'd0, fwd_wdata},   {32'd0, e.wdata});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic ld, input logic [1:0] sz,
                       input logic uns, input logic we, input logic [4:0] wa,
                       input logic [31:0] res, input logic [31:0] exp, input bit push);
    exp_t e;
    ex_valid = 1'b1; ex_pc = pc; ex_load = ld; ex_ld_size = sz;
    ex_ld_unsigned = uns; ex_rf_we = we; ex_rf_waddr = wa; ex_result = res;
    if (push) begin
      e.pc = pc; e.we = we; e.waddr = wa; e.wdata = exp;
      exp_q.push_back(e);
    end
    tick();
    ex_valid = 1'b0; ex_load = 1'b0; ex_rf_we = 1'b0;
  endtask

  task automatic load1(input logic [31:0] pc, input logic [1:0] sz, input logic uns,
                       input logic [4:0] wa, input logic [31:0] addr,
                       input logic [31:0] rdata, input logic [31:0] exp);
    issue(pc, 1'b1, sz, uns, 1'b1, wa, addr, exp, 1'b1);
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wb_valid"},    {63'd0, wb_valid},    64'd0);
    check({tag, "_wb_pc"},       {32'd0, wb_pc},       64'd0);
    check({tag, "_wb_rf_we"},    {63'd0, wb_rf_we},    64'd0);
    check({tag, "_wb_rf_waddr"}, {59'd0, wb_rf_waddr}, 64'd0);
    check({tag, "_wb_rf_wdata"}, {32'd0, wb_rf_wdata}, 64'd0);
    check({tag, "_fwd_pending"}, {63'd0, fwd_pending}, 64'd0);
    check({tag, "_stallreq"},    {63'd0, stallreq},    64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sr_cnt, fp_cnt, we_cnt, wa_bad;
    rst_n = 1'b0; base_stall = '0; ex_valid = 1'b0; ex_pc = '0; ex_load = 1'b0;
    ex_ld_size = '0; ex_ld_unsigned = 1'b0; ex_rf_we = 1'b0; ex_rf_waddr = '0;
    ex_result = '0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    #3;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // ALU ops, back to back
    issue(32'h100, 1'b0, 2'd0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h1234, 1'b1);
    issue(32'h104, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 32'hDEAD, 32'hDEAD, 1'b1);
    tick();

    // Byte loads
    load1(32'h200, 2'd0, 1'b0, 5'd1, 32'h1003, 32'h80AA_BB7F, 32'hFFFF_FF80);
    load1(32'h204, 2'd0, 1'b1, 5'd2, 32'h1003, 32'h80AA_BB7F, 32'h0000_0080);
    load1(32'h208, 2'd0, 1'b0, 5'd3, 32'h1000, 32'h80AA_BB7F, 32'h0000_007F);
    load1(32'h20C, 2'd0, 1'b0, 5'd4, 32'h1001, 32'h80AA_BB7F, 32'hFFFF_FFBB);
    // Half loads
    load1(32'h300, 2'd1, 1'b0, 5'd6, 32'h2002, 32'h8001_0000, 32'hFFFF_8001);
    load1(32'h304, 2'd1, 1'b0, 5'd6, 32'h2003, 32'h8001_0000, 32'hFFFF_8001);
    load1(32'h308, 2'd1, 1'b0, 5'd8, 32'h2000, 32'h8001_F00D, 32'hFFFF_F00D);
    load1(32'h30C, 2'd1, 1'b1, 5'd8, 32'h2001, 32'h8001_F00D, 32'h0000_F00D);
    // Word load, size 3, offset ignored
    load1(32'h310, 2'd3, 1'b0, 5'd10, 32'h3001, 32'hCAFE_BABE, 32'hCAFE_BABE);

    // Load with three cycles of response latency
    issue(32'h400, 1'b1, 2'd2, 1'b0, 1'b1, 5'd7, 32'h4000, 32'h1234_5678, 1'b1);
    sr_cnt = 0; fp_cnt = 0; we_cnt = 0; wa_bad = 0;
    for (int i = 0; i < 3; i++) begin
      dmem_rvalid = 1'b0; dmem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      if (stallreq) sr_cnt++;
      if (fwd_pending) fp_cnt++;
      if (wb_rf_we || wb_valid) we_cnt++;
      if (fwd_waddr != 5'd7) wa_bad++;
      tick();
    end
    check("lat_stallreq_cycles", 64'(sr_cnt), 64'd3);
    check("lat_fwd_pending_cycles", 64'(fp_cnt), 64'd3);
    check("lat_wb_we_while_waiting", 64'(we_cnt), 64'd0);
    check("lat_fwd_waddr", 64'(wa_bad), 64'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("lat_stallreq_on_rvalid", {63'd0, stallreq}, 64'd0);
    check("lat_fwd_pending_on_rvalid", {63'd0, fwd_pending}, 64'd0);
    tick();
    dmem_rvalid = 1'b0;
    tick();

    // Response during full stall goes to HOLD and stays stable
    issue(32'h500, 1'b1, 2'd1, 1'b1, 1'b1, 5'd9, 32'h5002, 32'h0000_BEEF, 1'b1);
    base_stall = 6'b011111;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF_1234;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("hold_wdata", {32'd0, wb_rf_wdata}, 64'h0000_BEEF);
      check("hold_stallreq", {63'd0, stallreq}, 64'd0);
      tick();
    end
    base_stall = '0;
    tick();
    tick();

    // Bubble: slot leaves to WB, then MEM is empty
    issue(32'h600, 1'b0, 2'd0, 1'b0, 1'b1, 5'd11, 32'h66, 32'h66, 1'b1);
    base_stall = 6'b001111;
    tick();
    @(negedge clk);
    check("bubble_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("bubble_wb_rf_we", {63'd0, wb_rf_we}, 64'd0);
    base_stall = '0;
    tick();

    // Reset while a load waits: response dropped, outputs cleared asynchronously
    issue(32'h700, 1'b1, 2'd2, 1'b0, 1'b1, 5'd12, 32'h7000, 32'h0, 1'b0);
    dmem_rvalid = 1'b0;
    #1;
    check("pre_reset_stallreq", {63'd0, stallreq}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
    @(negedge clk);
    check("post_reset_rvalid_ignored", {63'd0, wb_valid}, 64'd0);
    tick();
    dmem_rvalid = 1'b0;
    tick();
    tick();

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
